// File: rtl/bcd_cnt_pkg.sv
// ============================================================================
//  Package     : bcd_cnt_pkg
//  Description : Shared BCD digit type, digit limits and load validation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_cnt_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_bcd(bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage : bcd_cnt_pkg

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
//  Module      : bcd_digit
//  Description : Single BCD digit register with clear, load and up/down step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  input  logic       inc_en,
  input  logic       up,
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = BCD_MIN;
    end else if (ld) begin
      q_d = ld_val;
    end else if (inc_en) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == BCD_MAX);
  assign at_min = (q_q == BCD_MIN);

endmodule : bcd_digit

`default_nettype wire

// File: rtl/bcd_updown_counter.sv
// ============================================================================
//  Module      : bcd_updown_counter
//  Description : Multi-digit BCD up/down counter with clear, validated load,
//                wrap/saturate mode and cascade terminal count.
//                Optional match output enabled by macro BCD_CNT_MATCH_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_updown_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc_out,
  output logic                  wrap,
  output logic                  load_err
`ifdef BCD_CNT_MATCH_EN
  ,
  input  logic [4*DIGITS-1:0]   match_val,
  output logic                  match
`endif
);

  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_inc_en;
  logic [DIGITS-1:0] w_digit_ok;
  logic [DIGITS:0]   w_max_below;
  logic [DIGITS:0]   w_min_below;

  logic w_load_ok;
  logic w_ld;
  logic w_sat_hold;
  logic w_step;

  logic wrap_q,     wrap_d;
  logic load_err_q, load_err_d;

  assign w_max_below[0] = 1'b1;
  assign w_min_below[0] = 1'b1;

  // Ripple prefix: digit i steps only when every lower digit is at its limit.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_digit_ok[i]    = is_bcd(load_val[4*i +: 4]);
      assign w_max_below[i+1] = w_max_below[i] & w_at_max[i];
      assign w_min_below[i+1] = w_min_below[i] & w_at_min[i];
      assign w_inc_en[i]      = w_step & (up ? w_max_below[i] : w_min_below[i]);

      bcd_digit u_digit (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .ld     (w_ld),
        .ld_val (load_val[4*i +: 4]),
        .inc_en (w_inc_en[i]),
        .up     (up),
        .q      (count[4*i +: 4]),
        .at_max (w_at_max[i]),
        .at_min (w_at_min[i])
      );
    end
  endgenerate

  assign tc_out     = en & (up ? w_max_below[DIGITS] : w_min_below[DIGITS]);
  assign w_load_ok  = &w_digit_ok;
  assign w_ld       = load & ~clr & w_load_ok;
  assign w_sat_hold = (SATURATE != 0) & tc_out;
  assign w_step     = en & ~clr & ~load & ~w_sat_hold;

  // A step taken at the terminal value is necessarily a wrap.
  assign wrap_d     = w_step & tc_out;
  assign load_err_d = load & ~clr & ~w_load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

`ifdef BCD_CNT_MATCH_EN
  logic [4*DIGITS-1:0] prev_q;
  logic                match_q;
  logic                match_d;

  // Pulse only on arrival at match_val, not while holding there.
  assign match_d = (count == match_val) && (count != prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      match_q <= 1'b0;
    end else begin
      prev_q  <= count;
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule : bcd_updown_counter

`default_nettype wire

// File: tb/tb_bcd_updown_counter.sv
// ============================================================================
//  Module      : tb_bcd_updown_counter
//  Description : Self-checking bench for bcd_updown_counter, wrap and saturate
//                instances side by side; optional BCD_CNT_MATCH_EN checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_updown_counter;

  localparam int N    = 3;
  localparam int W    = 4 * N;
  localparam int MAXV = 999;

  logic         clk = 1'b0;
  logic         rst_n, clr, en, up, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count0, count1;
  logic         tc0, tc1, wrap0, wrap1, err0, err1;
`ifdef BCD_CNT_MATCH_EN
  logic [W-1:0] match_val;
  logic         match0, match1;
`endif

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIGITS(N), .SATURATE(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count0), .tc_out(tc0), .wrap(wrap0),
    .load_err(err0)
`ifdef BCD_CNT_MATCH_EN
    , .match_val(match_val), .match(match0)
`endif
  );

  bcd_updown_counter #(.DIGITS(N), .SATURATE(1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count1), .tc_out(tc1), .wrap(wrap1),
    .load_err(err1)
`ifdef BCD_CNT_MATCH_EN
    , .match_val(match_val), .match(match1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: plain decimal integers.
  int m0, m1;
  bit mw0, mw1, me0, me1;

  typedef struct {
    logic         clr, load, en, up;
    logic [W-1:0] lv;
    logic         tc0, tc1;
    logic [W-1:0] c0;
    logic         w0, err;
    logic [W-1:0] c1;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit valid_bcd(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit model_tc(input int m, input bit e, input bit u);
    return e && (u ? (m == MAXV) : (m == 0));
  endfunction

  task automatic model_next(input bit sat, input bit c, input bit l, input bit e,
                            input bit u, input logic [W-1:0] v,
                            inout int m, output bit w, output bit er);
    w  = 1'b0;
    er = 1'b0;
    if (c) begin
      m = 0;
    end else if (l) begin
      if (valid_bcd(v)) m = bcd2int(v);
      else er = 1'b1;
    end else if (e) begin
      if (u) begin
        if (m < MAXV) m = m + 1;
        else if (!sat) begin m = 0; w = 1'b1; end
      end else begin
        if (m > 0) m = m - 1;
        else if (!sat) begin m = MAXV; w = 1'b1; end
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic c, input logic l, input logic e, input logic u,
                      input logic [W-1:0] v);
    clr = c; load = l; en = e; up = u; load_val = v;
    #1;
    chk("tc_out_wrapinst", 32'(tc0), 32'(model_tc(m0, e, u)));
    chk("tc_out_satinst",  32'(tc1), 32'(model_tc(m1, e, u)));
    model_next(1'b0, c, l, e, u, v, m0, mw0, me0);
    model_next(1'b1, c, l, e, u, v, m1, mw1, me1);
    @(posedge clk);
    @(negedge clk);
    chk("count_wrapinst",    32'(count0), 32'(int2bcd(m0)));
    chk("count_satinst",     32'(count1), 32'(int2bcd(m1)));
    chk("wrap_wrapinst",     32'(wrap0),  32'(mw0));
    chk("wrap_satinst",      32'(wrap1),  32'(mw1));
    chk("load_err_wrapinst", 32'(err0),   32'(me0));
    chk("load_err_satinst",  32'(err1),   32'(me1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rv;
    int           r;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0, 12'h998, 1'b0, 1'b0, 12'h998};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0, 12'h999};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 12'h999};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 12'h999};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 12'h100};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h099, 1'b0, 1'b0, 12'h099};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h098, 1'b0, 1'b0, 12'h098};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h999, 1'b1, 1'b0, 12'h000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h999, 1'b0, 1'b0, 12'h999, 1'b0, 1'b0, 12'h999};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0, 12'h999};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 12'h001, 1'b0, 1'b0, 12'h999};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1, 12'h002, 1'b0, 1'b0, 12'h999};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 12'h998};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h1A3, 1'b0, 1'b0, 12'h001, 1'b0, 1'b1, 12'h998};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h1A3, 1'b0, 1'b0, 12'h001, 1'b0, 1'b1, 12'h998};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 12'h998};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h456, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0, 12'h456};
    tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h537, 1'b0, 1'b0, 12'h537, 1'b0, 1'b0, 12'h537};

    rst_n = 1'b0; clr = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
`ifdef BCD_CNT_MATCH_EN
    match_val = 12'h003;
`endif
    m0 = 0; m1 = 0;
    repeat (2) @(negedge clk);
    chk("reset_count_wrapinst", 32'(count0), 32'h0);
    chk("reset_count_satinst",  32'(count1), 32'h0);
    chk("reset_wrap",           32'({wrap0, wrap1}), 32'h0);
    chk("reset_load_err",       32'({err0, err1}), 32'h0);
    rst_n = 1'b1;

    // Increment from zero: 001..012 with no terminal count or wrap.
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      chk("inc_seq_count", 32'(count0), 32'(int2bcd(i + 1)));
    end

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].clr, tbl[i].load, tbl[i].en, tbl[i].up, tbl[i].lv);
      chk("tbl_count_wrapinst", 32'(count0), 32'(tbl[i].c0));
      chk("tbl_count_satinst",  32'(count1), 32'(tbl[i].c1));
      chk("tbl_wrap",           32'(wrap0),  32'(tbl[i].w0));
      chk("tbl_load_err",       32'(err0),   32'(tbl[i].err));
    end

    // Async reset between edges at count 537.
    clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; load_val = '0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_count_wrapinst", 32'(count0), 32'h0);
    chk("async_reset_count_satinst",  32'(count1), 32'h0);
    m0 = 0; m1 = 0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef BCD_CNT_MATCH_EN
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, '0);
      chk("match_pulse", 32'(match0), 32'(i == 4));
    end
`endif

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
        if (r < 8) rv = W'($urandom);
        else if (r < 12) rv = 12'h999;
        else if (r < 16) rv = 12'h000;
        else rv = int2bcd(int'($urandom_range(0, MAXV)));
      end else begin
        rv = W'($urandom);
      end
      step(r >= 96, r < 25, $urandom_range(0, 3) != 0, 1'($urandom), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd_updown_counter

`default_nettype wire

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter with up/down direction, synchronous clear, parallel load with BCD validation, wrap or saturate mode, and cascade terminal-count output.
- Next generation of the team's single-digit modulo-10 counter.
- Used for decimal event and timer counting, where several instances chain through tc_out into en.

Parameters:
- DIGITS, 3, number of BCD digits (1..8); count width is 4*DIGITS.
- SATURATE, 0, 0 = wrap at the ends of the range; 1 = hold at the ends of the range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear to zero.
- en  in  1  count enable (the cascade input).
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load request.
- load_val  in  4*DIGITS  load value; digit i is in bits [4i+3:4i].
- count  out  4*DIGITS  registered BCD count; digit 0 is the least significant.
- tc_out  out  1  combinational terminal count, for cascading.
- wrap  out  1  registered one-cycle pulse on a wrap event.
- load_err  out  1  registered one-cycle pulse when a load is rejected.

Behaviour:
- Reset: when rst_n is 0, immediately set count=0, wrap=0, load_err=0. This also applies mid-operation.
- Priority each edge: clr > load > en. Lower-priority requests in the same cycle are ignored, with no error.
- clr: count becomes 0 on the next edge. Clears wrap and load_err.
- Load with every load_val digit <= 9: count takes load_val on the next edge.
- Load with any digit >= 10 (A-F): count is unchanged and load_err=1 for exactly one cycle. Applying load for N cycles gives N pulses.
- Count, en=1, up=1: standard BCD increment.
  - A digit at 9 goes to 0 and carries into the next digit.
  - Carry enters digit i only if all lower digits are 9.
- Count, en=1, up=0: BCD decrement.
  - A digit at 0 goes to 9 and borrows from the next digit.
- en=0: count holds.
- tc_out = en & (up ? all digits == 9 : all digits == 0). It is purely combinational from registered count and the inputs, with zero latency for the ripple enable.
- At the terminal value with en=1:
  - SATURATE=0: count wraps (999->000 up, 000->999 down) and wrap=1 for the next cycle only.
  - SATURATE=1: count holds, wrap stays 0, and tc_out remains 1 while en=1.
- Changing direction takes effect on the same edge; there is no pipeline. Latency from input to count is 1 cycle.
- count never holds a non-BCD digit under any input sequence.
- wrap and load_err default to 0 on every cycle without an event.

Optional Feature:
- Macro BCD_CNT_MATCH_EN.
- Defined: adds ports match_val (in, 4*DIGITS) and match (out, 1).
  - match is a registered one-cycle pulse, set the cycle after count transitions into a value equal to match_val by counting, load, or clr.
  - Holding at that value does not re-pulse.
  - Reset value of match is 0.
- Not defined: no extra ports or logic. The counter behaves identically otherwise.

Decomposition:
- Package bcd_cnt_pkg:
  - localparam BCD_MAX = 4'd9, BCD_MIN = 4'd0.
  - typedef logic [3:0] bcd_digit_t.
  - Function is_bcd(bcd_digit_t) for load validation.
- Sub-module bcd_digit, instantiated DIGITS times via generate.
  - Inputs: clk, rst_n, clr, ld, ld_val, inc_en, up.
  - Outputs: q, at_max (q==9), at_min (q==0).
  - Top-level logic handles carry chaining (inc_en[i] = en & all lower at_max/at_min), validation, saturation, and pulses.

Test Plan (DIGITS=3):
- Reset and increment: rst_n low then high, en=1, up=1 for 12 cycles -> count 000,001,...,009,010,011,012. tc_out=0, wrap=0 throughout.
- Decade carry and wrap, SATURATE=0: load 998, up=1, en=1 for 3 edges -> 999 (tc_out=1), 000 with wrap=1 for one cycle, 001 with wrap=0.
- Down and borrow: load 100, up=0, en=1 -> 099, 098. Load 000, en=1 -> 999 with wrap pulse. tc_out=1 while count=000 and up=0.
- Saturate, SATURATE=1: load 999, up=1, en=1 for 5 cycles -> count stays 999, tc_out=1, wrap=0. Switch up=0 -> 998.
- Load validation and priority:
  - load_val=0x1A3 -> count unchanged, load_err=1 for one cycle.
  - load=1 with clr=1 -> count=000, no load_err.
  - load=1 with en=1 and load_val=0x456 -> count 456, not 457.
- Async reset mid-count: count=537, drop rst_n between edges -> count=000 immediately, with no clock edge required. With BCD_CNT_MATCH_EN and match_val=003, counting up from 000 -> match pulse one cycle after count=003.
